// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander: loads one 512-bit block and streams W0..W(ROUNDS-1)
// over a valid/ready handshake, computing each new word with a 4-operand Kogge-Stone sum.

module sha256_ks_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);
  localparam int LV = $clog2(W);

  logic [LV:0][W-1:0]   w_g;
  logic [LV-1:0][W-1:0] w_p;

  assign w_g[0] = i_a & i_b;
  assign w_p[0] = i_a ^ i_b;

  // Prefix tree, carry-in 0: after LV levels w_g[LV][i] is the carry out of bit i.
  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int D = 1 << l;
    assign w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << D));
    if (l + 1 < LV) begin : g_prop
      assign w_p[l+1] = w_p[l] & (w_p[l] << D);
    end
  end

  assign o_sum = w_p[0] ^ (w_g[LV] << 1);
endmodule

module sha256_msg_sched #(
  parameter  int ROUNDS = 64,
  localparam int IDXW   = $clog2(ROUNDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic [511:0]    blk_data,
  output logic            w_valid,
  input  logic            w_ready,
  output logic [31:0]     w_data,
  output logic [IDXW-1:0] w_idx,
  output logic            w_last
);
  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must be in 16..64");
  end

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [15:0][31:0] r_win;
  logic [IDXW-1:0]   r_idx;

  logic        w_blk_fire;
  logic        w_word_fire;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_sum_a;
  logic [31:0] w_sum_b;
  logic [31:0] w_nxt;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // All handshake-side outputs decode from registers only.
  assign blk_ready = (r_state == S_IDLE);
  assign w_valid   = (r_state == S_RUN);
  assign w_data    = r_win[0];
  assign w_idx     = r_idx;
  assign w_last    = w_valid && (r_idx == IDXW'(ROUNDS - 1));

  assign w_blk_fire  = blk_valid && blk_ready;
  assign w_word_fire = w_valid && w_ready;

  assign w_s0 = sig0(r_win[1]);
  assign w_s1 = sig1(r_win[14]);

  sha256_ks_add #(.W(32)) u_add_a (.i_a(w_s1),    .i_b(r_win[9]), .o_sum(w_sum_a));
  sha256_ks_add #(.W(32)) u_add_b (.i_a(w_s0),    .i_b(r_win[0]), .o_sum(w_sum_b));
  sha256_ks_add #(.W(32)) u_add_c (.i_a(w_sum_a), .i_b(w_sum_b),  .o_sum(w_nxt));

  // NOTE: every signal an always_comb writes gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (blk_valid)          w_state_nxt = S_RUN;
      S_RUN:   if (w_ready && w_last)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the window is cleared on reset so w_data reads 0 afterwards; it is plain flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_blk_fire) begin
        for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511 - 32*i -: 32];
        r_idx <= '0;
      end else if (w_word_fire) begin
        r_win <= {w_nxt, r_win[15:1]};
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: "abc" vector table, backpressure, busy-block,
// back-to-back, reset and randomized blocks against an array-based schedule model.

module tb_sha256_msg_sched;
  localparam int R = 64;

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [R];
  logic [31:0] got   [R];
  vec_t        abc_tab [6];

  always #5 clk = ~clk;

  sha256_msg_sched #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void build_model(input logic [511:0] b);
    for (int t = 0; t < R; t++) begin
      if (t < 16) model[t] = b[511 - 32*t -: 32];
      else        model[t] = s1(model[t-2]) + model[t-7] + s0(model[t-15]) + model[t-16];
    end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
    return b;
  endfunction

  task automatic load_block(input logic [511:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("blk_ready_before_load", blk_ready, 1);
    blk_valid = 1'b1;
    blk_data  = b;
  endtask

  // Streams one block; checks every presented word against the model.
  task automatic collect(input logic [511:0] blk, input int ready_pct,
                         input int stall_idx, input int stall_len,
                         input int intr_idx, input logic [511:0] alt, input bit hold,
                         input int rst_idx, output int cycles, output bit aborted);
    int exp_t;
    int stall;
    bit rdy;
    build_model(blk);
    exp_t   = 0;
    cycles  = 0;
    stall   = 0;
    aborted = 1'b0;
    while (exp_t < R && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      check("w_valid_run", w_valid, 1);
      check("blk_ready_busy", blk_ready, 0);
      check("w_idx", 32'(w_idx), exp_t);
      check("w_data", w_data, model[exp_t]);
      check("w_last", w_last, exp_t == R - 1);
      if (rst_idx >= 0 && exp_t == rst_idx) begin
        rst     = 1'b1;
        w_ready = 1'b0;
        aborted = 1'b1;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (exp_t == stall_idx && stall < stall_len) begin
        rdy = 1'b0;
        stall++;
      end
      if (hold || (intr_idx >= 0 && exp_t >= intr_idx && exp_t < intr_idx + 4)) begin
        blk_valid = 1'b1;
        blk_data  = alt;
      end else begin
        blk_valid = 1'b0;
      end
      w_ready = rdy;
      if (rdy) begin
        got[exp_t] = w_data;
        exp_t++;
      end
    end
    if (!aborted && exp_t < R) check("stream_timeout", exp_t, R);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check({name, "_w_valid"}, w_valid, 0);
    check({name, "_blk_ready"}, blk_ready, 1);
    check({name, "_w_last"}, w_last, 0);
  endtask

  task automatic check_abc_table();
    for (int i = 0; i < 6; i++)
      check($sformatf("abc_W%0d", abc_tab[i].idx), got[abc_tab[i].idx], abc_tab[i].exp);
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    int           cyc;
    bit           ab;

    abc_tab[0] = '{0,  32'h61626380};
    abc_tab[1] = '{1,  32'h00000000};
    abc_tab[2] = '{15, 32'h00000018};
    abc_tab[3] = '{16, 32'h61626380};
    abc_tab[4] = '{17, 32'h000F0000};
    abc_tab[5] = '{18, 32'h7DA86405};
    abc = {32'h61626380, 448'h0, 32'h00000018};

    rst = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_w_valid", w_valid, 0);
    check("rst_blk_ready", blk_ready, 1);
    check("rst_w_idx", 32'(w_idx), 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_last", w_last, 0);
    rst = 1'b0;

    // "abc" with w_ready held high: 64 back-to-back words.
    load_block(abc);
    collect(abc, 100, -1, 0, -1, '0, 1'b0, -1, cyc, ab);
    check("abc_cycles", cyc, R);
    check_abc_table();
    idle_check("abc_done");

    // Backpressure for 5 cycles at W17.
    load_block(abc);
    collect(abc, 100, 17, 5, -1, '0, 1'b0, -1, cyc, ab);
    check("bp_cycles", cyc, R + 5);
    idle_check("bp_done");

    // A different block offered while busy is ignored.
    load_block(abc);
    collect(abc, 100, -1, 0, 30, rand_block(), 1'b0, -1, cyc, ab);
    idle_check("intr_done");

    // Back-to-back with blk_valid held high: one bubble cycle.
    blk_a = rand_block();
    blk_b = rand_block();
    load_block(blk_a);
    collect(blk_a, 100, -1, 0, -1, blk_b, 1'b1, -1, cyc, ab);
    @(negedge clk);
    check("b2b_bubble_w_valid", w_valid, 0);
    check("b2b_bubble_blk_ready", blk_ready, 1);
    collect(blk_b, 100, -1, 0, -1, '0, 1'b0, -1, cyc, ab);
    check("b2b_second_cycles", cyc, R);
    idle_check("b2b_done");

    // Block handshake coincident with reset is discarded.
    @(negedge clk);
    rst       = 1'b1;
    blk_valid = 1'b1;
    blk_data  = abc;
    @(negedge clk);
    rst       = 1'b0;
    blk_valid = 1'b0;
    check("rst_hs_w_valid", w_valid, 0);
    @(negedge clk);
    check("rst_hs_w_valid_later", w_valid, 0);
    check("rst_hs_blk_ready", blk_ready, 1);

    // Reset mid-run at W40, then reload.
    load_block(abc);
    collect(abc, 100, -1, 0, -1, '0, 1'b0, 40, cyc, ab);
    check("midrst_reached", ab, 1);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_w_valid", w_valid, 0);
    check("midrst_blk_ready", blk_ready, 1);
    check("midrst_w_idx", 32'(w_idx), 0);
    check("midrst_w_data", w_data, 0);
    check("midrst_w_last", w_last, 0);
    @(negedge clk);
    check("midrst_no_resume", w_valid, 0);
    load_block(abc);
    collect(abc, 100, -1, 0, -1, '0, 1'b0, -1, cyc, ab);
    check_abc_table();
    idle_check("reload_done");

    // Random blocks with random w_ready.
    for (int k = 0; k < 4; k++) begin
      blk_a = rand_block();
      load_block(blk_a);
      collect(blk_a, 60, -1, 0, -1, '0, 1'b0, -1, cyc, ab);
      idle_check($sformatf("rand%0d_done", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
